// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate walks all taps per accepted sample,
// then rounds half-up, saturates to DW and holds the result until the consumer takes it.
module fir_mac_sequencer #(
    parameter int NTAPS = 8,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int ACCW  = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DW-1:0]     x_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DW-1:0]     y_out,
    input  logic                     cfg_we,
    input  logic [$clog2(NTAPS)-1:0] cfg_addr,
    input  logic signed [CW-1:0]     cfg_coef,
    output logic                     cfg_err,
    input  logic                     clr_hist
);
    localparam int AW = $clog2(NTAPS);
    localparam int PW = DW + CW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [ACCW-1:0] RND     = ACCW'(1) <<< (CW - 2);
    localparam logic signed [ACCW-1:0] SAT_MAX = (ACCW'(1) <<< (DW - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]             state;
    logic signed [DW-1:0]   xmem [NTAPS];
    logic signed [CW-1:0]   cmem [NTAPS];
    logic signed [ACCW-1:0] acc;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          k;
    logic [AW-1:0]          rd_idx;
    logic [AW-1:0]          wr_idx;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic                   accept;

    // Q1.(CW-1) product back to sample scale: add half an LSB, arithmetic shift, clamp.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] r;
        r = (a + RND) >>> (CW - 1);
        if (r > SAT_MAX)
            return SAT_MAX[DW-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[DW-1:0];
        return r[DW-1:0];
    endfunction

    always_comb begin
        accept   = in_valid && in_ready;
        rd_idx   = wr_ptr - k;
        wr_idx   = clr_hist ? '0 : wr_ptr;
        prod     = cmem[k] * xmem[rd_idx];
        prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
            cfg_err   <= 1'b0;
            acc       <= '0;
            wr_ptr    <= '0;
            k         <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                xmem[i] <= '0;
                cmem[i] <= '0;
            end
        end else begin
            cfg_err <= cfg_we && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (cfg_we)
                        cmem[cfg_addr] <= cfg_coef;
                    // Clearing first lets a coincident sample land in the freshly zeroed slot 0.
                    if (clr_hist) begin
                        for (int i = 0; i < NTAPS; i++)
                            xmem[i] <= '0;
                        wr_ptr <= '0;
                    end
                    if (accept) begin
                        xmem[wr_idx] <= x_in;
                        acc          <= '0;
                        k            <= '0;
                        in_ready     <= 1'b0;
                        state        <= S_MAC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + AW'(1);
                    if (k == AW'(NTAPS - 1))
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    y_out     <= round_sat(acc);
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        wr_ptr    <= wr_ptr + AW'(1);
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
